// File: rtl/dmem2_pkg.sv
// Shared defaults and FSM encoding for the two-slot data memory responder.
package dmem2_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4096;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVE_B = 1'b1
  } state_t;
endpackage

// File: rtl/dmem2_responder_if.sv
// Two-slot request/response bundle: slot a is the older request, slot b the younger.
interface dmem2_responder_if
  import dmem2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic [ADDR_W-1:0] address_a;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              wren_a;
  logic              wren_b;
  logic              rden_a;
  logic              rden_b;
  logic [DATA_W-1:0] q_a;
  logic [DATA_W-1:0] q_b;
  logic              valid_a;
  logic              valid_b;
  logic              stall;

  modport master (
    output address_a, address_b, data_a, data_b, wren_a, wren_b, rden_a, rden_b,
    input  q_a, q_b, valid_a, valid_b, stall
  );

  modport slave (
    input  address_a, address_b, data_a, data_b, wren_a, wren_b, rden_a, rden_b,
    output q_a, q_b, valid_a, valid_b, stall
  );
endinterface

// File: rtl/dmem2_responder_sp_ram.sv
// Single-port storage array: synchronous write, registered read, contents never reset.
module sp_ram
  import dmem2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem2_responder.sv
// Two-slot front end to a single-ported memory: serialises a/b pairs, a first, b one cycle later.
module dmem2_responder
  import dmem2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  dmem2_responder_if.slave   bus
);
  state_t            state, next_state;
  logic              req_a, req_b;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              rd_a_p0, rd_b_p0, pend_load;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              pend_we;
  logic              vld_a_p1, vld_b_p1;
  logic [DATA_W-1:0] hold_a, hold_b;

  assign req_a = bus.wren_a | bus.rden_a;
  assign req_b = bus.wren_b | bus.rden_b;

  // Access arbitration is gated by reset so nothing touches the array while held in reset.
  always_comb begin
    next_state = state;
    bus.stall  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = bus.address_a;
    ram_wdata  = bus.data_a;
    rd_a_p0    = 1'b0;
    rd_b_p0    = 1'b0;
    pend_load  = 1'b0;
    if (reset) begin
      unique case (state)
        IDLE: begin
          if (req_a) begin
            ram_en  = 1'b1;
            ram_we  = bus.wren_a;
            rd_a_p0 = ~bus.wren_a;
            if (req_b) begin
              pend_load  = 1'b1;
              bus.stall  = 1'b1;
              next_state = SERVE_B;
            end
          end else if (req_b) begin
            ram_en    = 1'b1;
            ram_we    = bus.wren_b;
            ram_addr  = bus.address_b;
            ram_wdata = bus.data_b;
            rd_b_p0   = ~bus.wren_b;
          end
        end
        SERVE_B: begin
          ram_en     = 1'b1;
          ram_we     = pend_we;
          ram_addr   = pend_addr;
          ram_wdata  = pend_data;
          rd_b_p0    = ~pend_we;
          next_state = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_addr <= '0;
      pend_data <= '0;
      pend_we   <= 1'b0;
    end else if (pend_load) begin
      pend_addr <= bus.address_b;
      pend_data <= bus.data_b;
      pend_we   <= bus.wren_b;
    end
  end

  sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ---- stage p1: read data leaves the array; hold registers keep it per slot ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_a_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
      hold_a   <= '0;
      hold_b   <= '0;
    end else begin
      vld_a_p1 <= rd_a_p0;
      vld_b_p1 <= rd_b_p0;
      if (vld_a_p1) hold_a <= ram_rdata;
      if (vld_b_p1) hold_b <= ram_rdata;
    end
  end

  assign bus.valid_a = vld_a_p1;
  assign bus.valid_b = vld_b_p1;
  assign bus.q_a     = vld_a_p1 ? ram_rdata : hold_a;
  assign bus.q_b     = vld_b_p1 ? ram_rdata : hold_b;
endmodule

// File: tb/tb_dmem2_responder.sv
// Randomised self-checking bench for dmem2_responder against a sequential memory model.
module tb_dmem2_responder;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  logic [31:0] mem_m [4096];
  logic [31:0] q_a_m, q_b_m;
  logic [11:0] pool [8];

  dmem2_responder_if bus ();

  dmem2_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one request pair, holds it through the served cycles and checks every cycle.
  task automatic run_pair(input bit wa, input bit ra, input logic [11:0] aa, input logic [31:0] da,
                          input bit wb, input bit rb, input logic [11:0] ab, input logic [31:0] db,
                          input string tag);
    bit          req_a, req_b, dual, va_exp, vb_exp;
    logic [31:0] qb_new;
    req_a = wa | ra;
    req_b = wb | rb;
    dual  = req_a && req_b;
    bus.wren_a = wa; bus.rden_a = ra; bus.address_a = aa; bus.data_a = da;
    bus.wren_b = wb; bus.rden_b = rb; bus.address_b = ab; bus.data_b = db;
    va_exp = 1'b0;
    vb_exp = 1'b0;
    qb_new = q_b_m;
    if (req_a) begin
      if (wa) mem_m[aa] = da;
      else begin va_exp = 1'b1; q_a_m = mem_m[aa]; end
    end
    if (req_b) begin
      if (wb) mem_m[ab] = db;
      else begin vb_exp = 1'b1; qb_new = mem_m[ab]; end
    end
    #1;
    n_cmp++;
    if (bus.stall !== dual) begin
      n_fail++; $display("FAIL %s stall: got %b want %b", tag, bus.stall, dual);
    end
    @(posedge clock); #1;
    n_cmp += 2;
    if (bus.valid_a !== va_exp) begin
      n_fail++; $display("FAIL %s valid_a: got %b want %b", tag, bus.valid_a, va_exp);
    end
    if (bus.q_a !== q_a_m) begin
      n_fail++; $display("FAIL %s q_a: got %h want %h", tag, bus.q_a, q_a_m);
    end
    if (!dual) begin
      q_b_m = qb_new;
      n_cmp += 2;
      if (bus.valid_b !== vb_exp) begin
        n_fail++; $display("FAIL %s valid_b: got %b want %b", tag, bus.valid_b, vb_exp);
      end
      if (bus.q_b !== q_b_m) begin
        n_fail++; $display("FAIL %s q_b: got %h want %h", tag, bus.q_b, q_b_m);
      end
    end else begin
      n_cmp += 3;
      if (bus.valid_b !== 1'b0) begin
        n_fail++; $display("FAIL %s early valid_b: got %b want 0", tag, bus.valid_b);
      end
      if (bus.q_b !== q_b_m) begin
        n_fail++; $display("FAIL %s early q_b: got %h want %h", tag, bus.q_b, q_b_m);
      end
      if (bus.stall !== 1'b0) begin
        n_fail++; $display("FAIL %s serve stall: got %b want 0", tag, bus.stall);
      end
      @(posedge clock); #1;
      q_b_m = qb_new;
      n_cmp += 4;
      if (bus.valid_a !== 1'b0) begin
        n_fail++; $display("FAIL %s late valid_a: got %b want 0", tag, bus.valid_a);
      end
      if (bus.q_a !== q_a_m) begin
        n_fail++; $display("FAIL %s late q_a: got %h want %h", tag, bus.q_a, q_a_m);
      end
      if (bus.valid_b !== vb_exp) begin
        n_fail++; $display("FAIL %s valid_b: got %b want %b", tag, bus.valid_b, vb_exp);
      end
      if (bus.q_b !== q_b_m) begin
        n_fail++; $display("FAIL %s q_b: got %h want %h", tag, bus.q_b, q_b_m);
      end
    end
  endtask

  task automatic idle_inputs();
    bus.wren_a = 0; bus.rden_a = 0; bus.address_a = '0; bus.data_a = '0;
    bus.wren_b = 0; bus.rden_b = 0; bus.address_b = '0; bus.data_b = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    q_a_m = '0;
    q_b_m = '0;
    #2;
    n_cmp += 5;
    if (bus.q_a !== 32'h0)   begin n_fail++; $display("FAIL reset q_a: got %h want 0", bus.q_a); end
    if (bus.q_b !== 32'h0)   begin n_fail++; $display("FAIL reset q_b: got %h want 0", bus.q_b); end
    if (bus.valid_a !== 0)   begin n_fail++; $display("FAIL reset valid_a: got %b want 0", bus.valid_a); end
    if (bus.valid_b !== 0)   begin n_fail++; $display("FAIL reset valid_b: got %b want 0", bus.valid_b); end
    if (bus.stall !== 0)     begin n_fail++; $display("FAIL reset stall: got %b want 0", bus.stall); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    run_pair(1, 0, 12'h010, 32'hDEADBEEF, 0, 0, '0, '0, "sr_wr");
    run_pair(0, 1, 12'h010, 32'h0, 0, 0, '0, '0, "sr_rd");
    n_cmp++;
    if (q_a_m !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sr_model q_a: got %h want deadbeef", q_a_m); end
  endtask

  task automatic test_dual_wr_rd();
    run_pair(1, 0, 12'h020, 32'h11111111, 0, 1, 12'h020, '0, "dual_wr_rd");
    run_pair(0, 0, '0, '0, 0, 0, '0, '0, "idle_after_dual");
  endtask

  task automatic test_dual_write();
    run_pair(1, 0, 12'h030, 32'hAAAA0000, 1, 0, 12'h030, 32'hBBBB0000, "dual_wr_wr");
    run_pair(0, 1, 12'h030, '0, 0, 0, '0, '0, "dual_wr_wr_rd");
    run_pair(0, 1, 12'h010, '0, 1, 0, 12'h010, 32'h0BADF00D, "rd_a_wr_b");
    run_pair(0, 0, '0, '0, 0, 1, 12'h010, '0, "rd_a_wr_b_chk");
  endtask

  task automatic test_write_with_rden();
    run_pair(0, 0, '0, '0, 1, 1, 12'hFFF, 32'h7, "wr_rden_b");
    run_pair(0, 0, '0, '0, 0, 1, 12'hFFF, '0, "wr_rden_b_rd");
  endtask

  task automatic test_reset_mid_op();
    run_pair(1, 0, 12'h040, 32'h12345678, 0, 0, '0, '0, "rst_prep");
    bus.wren_a = 1; bus.rden_a = 0; bus.address_a = 12'h050; bus.data_a = 32'h99;
    bus.wren_b = 1; bus.rden_b = 0; bus.address_b = 12'h040; bus.data_b = 32'h5;
    mem_m[12'h050] = 32'h99;
    @(posedge clock); #1;
    reset = 1'b0;
    q_a_m = '0;
    q_b_m = '0;
    #1;
    n_cmp += 5;
    if (bus.q_a !== 32'h0) begin n_fail++; $display("FAIL midrst q_a: got %h want 0", bus.q_a); end
    if (bus.q_b !== 32'h0) begin n_fail++; $display("FAIL midrst q_b: got %h want 0", bus.q_b); end
    if (bus.valid_a !== 0) begin n_fail++; $display("FAIL midrst valid_a: got %b want 0", bus.valid_a); end
    if (bus.valid_b !== 0) begin n_fail++; $display("FAIL midrst valid_b: got %b want 0", bus.valid_b); end
    if (bus.stall !== 0)   begin n_fail++; $display("FAIL midrst stall: got %b want 0", bus.stall); end
    @(posedge clock); #1;
    idle_inputs();
    @(posedge clock); #1;
    reset = 1'b1;
    run_pair(0, 1, 12'h040, '0, 0, 0, '0, '0, "post_rst_rd");
    n_cmp++;
    if (q_a_m !== 32'h12345678) begin n_fail++; $display("FAIL midrst_model: got %h want 12345678", q_a_m); end
    run_pair(0, 0, '0, '0, 0, 1, 12'h050, '0, "post_rst_rd_b");
  endtask

  task automatic test_back_to_back();
    bit          wa, ra, wb, rb;
    int unsigned op;
    for (int i = 0; i < 8; i++) begin
      pool[i] = (i == 7) ? 12'hFFF : 12'(12'h100 + 12'(i * 37));
      run_pair(0, 0, '0, '0, 1, 0, pool[i], $urandom, "b2b_init");
    end
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      wa = (op >= 2); ra = (op == 1) || (op == 3);
      op = $urandom_range(0, 3);
      wb = (op >= 2); rb = (op == 1) || (op == 3);
      run_pair(wa, ra, pool[$urandom_range(0, 7)], $urandom,
               wb, rb, pool[$urandom_range(0, 7)], $urandom, "b2b_rand");
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single_read();
    test_dual_wr_rd();
    test_dual_write();
    test_write_with_rden();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
